// File: rtl/whack_scorer.sv
// Whack-a-mole input stage: switch sync/debounce, hit/miss classification and BCD score.
// Optional macro WHACK_MISS_PENALTY_EN makes misses subtract from the score.
module whack_scorer #(
  parameter int unsigned NUM_HOLES = 8,
  parameter int unsigned DEB_TICKS = 16,
  parameter int unsigned PEND_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_tick,
  input  logic                 i_game_en,
  input  logic [NUM_HOLES-1:0] i_sw,
  input  logic [NUM_HOLES-1:0] i_moles,
  output logic [NUM_HOLES-1:0] o_hit_clr,
  output logic                 o_hit_pulse,
  output logic                 o_miss_pulse,
  output logic [15:0]          o_score_bcd,
  output logic                 o_score_sat
);

  localparam int unsigned CNT_W = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam int unsigned POP_W = $clog2(NUM_HOLES + 1);
  localparam int unsigned SUM_W = PEND_W + POP_W;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEB_TICKS - 1);
  localparam logic [SUM_W-1:0]  PEND_MAX  = SUM_W'((1 << PEND_W) - 1);
  localparam logic [15:0]       SCORE_MAX = 16'h9999;

  typedef enum logic {S_IDLE = 1'b0, S_ADJ = 1'b1} state_t;

  function automatic logic [POP_W-1:0] popcount(input logic [NUM_HOLES-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < NUM_HOLES; i++) n = n + POP_W'(v[i]);
    return n;
  endfunction

  // Pending counter update: remove the unit being stepped, add new arrivals, saturate.
  function automatic logic [PEND_W-1:0] pend_next(input logic [PEND_W-1:0] cur,
                                                  input logic dec,
                                                  input logic [POP_W-1:0] inc);
    logic [SUM_W-1:0] s;
    s = SUM_W'(cur) + SUM_W'(inc) - SUM_W'(dec);
    return (s > PEND_MAX) ? PEND_MAX[PEND_W-1:0] : s[PEND_W-1:0];
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] s);
    logic [15:0] r;
    logic        c;
    r = s;
    c = (s != SCORE_MAX);
    for (int unsigned i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = 4'(r[4*i +: 4] + 4'd1);
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] s);
    logic [15:0] r;
    logic        b;
    r = s;
    b = (s != 16'h0000);
    for (int unsigned i = 0; i < 4; i++) begin
      if (b) begin
        if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
        else begin
          r[4*i +: 4] = 4'(r[4*i +: 4] - 4'd1);
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [NUM_HOLES-1:0] r_sw_m, r_sw_s, r_stable, r_tog;
  logic [CNT_W-1:0]     r_cnt [NUM_HOLES];
  logic                 r_primed, r_en_prev;
  logic [NUM_HOLES-1:0] r_hit_clr;
  logic                 r_hit_pulse, r_miss_pulse;
  logic [PEND_W-1:0]    r_pend_add, r_pend_sub;
  logic [15:0]          r_score;
  logic                 r_sat;
  state_t               r_state;

  logic [NUM_HOLES-1:0] w_hit, w_miss;
  logic                 w_new_game, w_step_add, w_step_sub;
  logic [PEND_W-1:0]    w_add_nxt, w_sub_nxt;
  logic [15:0]          w_score_nxt;

  // Synchroniser keeps running through reset so levels are settled when priming samples them.
  always_ff @(posedge clk) begin
    r_sw_m <= i_sw;
    r_sw_s <= r_sw_m;
  end

  // Per-bit debounce; the first tick after reset adopts the current levels silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable <= '0;
      r_tog    <= '0;
      r_primed <= 1'b0;
      for (int unsigned i = 0; i < NUM_HOLES; i++) r_cnt[i] <= '0;
    end else begin
      r_tog <= '0;
      if (i_tick) begin
        if (!r_primed) begin
          r_primed <= 1'b1;
          r_stable <= r_sw_s;
          for (int unsigned i = 0; i < NUM_HOLES; i++) r_cnt[i] <= '0;
        end else begin
          for (int unsigned i = 0; i < NUM_HOLES; i++) begin
            if (r_sw_s[i] != r_stable[i]) begin
              if (r_cnt[i] == CNT_LAST) begin
                r_stable[i] <= r_sw_s[i];
                r_cnt[i]    <= '0;
                r_tog[i]    <= 1'b1;
              end else begin
                r_cnt[i] <= CNT_W'(r_cnt[i] + 1'b1);
              end
            end else begin
              r_cnt[i] <= '0;
            end
          end
        end
      end
    end
  end

  assign w_hit      = i_game_en ? (r_tog & i_moles)  : '0;
  assign w_miss     = i_game_en ? (r_tog & ~i_moles) : '0;
  assign w_new_game = i_game_en & ~r_en_prev;

  // Registered event outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_clr    <= '0;
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
      r_en_prev    <= 1'b0;
    end else begin
      r_hit_clr    <= w_hit;
      r_hit_pulse  <= |w_hit;
      r_miss_pulse <= |w_miss;
      r_en_prev    <= i_game_en;
    end
  end

  assign w_step_add  = (r_state == S_ADJ) && (r_pend_add != '0);
  assign w_step_sub  = (r_state == S_ADJ) && (r_pend_add == '0) && (r_pend_sub != '0);
  assign w_add_nxt   = pend_next(r_pend_add, w_step_add, popcount(w_hit));
`ifdef WHACK_MISS_PENALTY_EN
  assign w_sub_nxt   = pend_next(r_pend_sub, w_step_sub, popcount(w_miss));
`else
  assign w_sub_nxt   = '0;
`endif
  assign w_score_nxt = w_step_add ? bcd_inc(r_score) :
                       w_step_sub ? bcd_dec(r_score) : r_score;

  // Score FSM: drains pending adds first, then pending subtracts, one BCD step per cycle.
  always_ff @(posedge clk) begin
    if (rst || w_new_game) begin
      r_state    <= S_IDLE;
      r_score    <= '0;
      r_sat      <= 1'b0;
      r_pend_add <= '0;
      r_pend_sub <= '0;
    end else begin
      r_pend_add <= w_add_nxt;
      r_pend_sub <= w_sub_nxt;
      r_score    <= w_score_nxt;
      r_sat      <= (w_score_nxt == SCORE_MAX);
      case (r_state)
        S_IDLE:  if (r_pend_add != '0 || r_pend_sub != '0) r_state <= S_ADJ;
        S_ADJ:   if (w_add_nxt == '0 && w_sub_nxt == '0) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_hit_clr    = r_hit_clr;
  assign o_hit_pulse  = r_hit_pulse;
  assign o_miss_pulse = r_miss_pulse;
  assign o_score_bcd  = r_score;
  assign o_score_sat  = r_sat;

endmodule

// File: tb/tb_whack_scorer.sv
// Self-checking bench for whack_scorer: directed table, corner sequences and randomized
// events against an integer score model.
module tb_whack_scorer;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_tick = 1'b0;
  logic        i_game_en;
  logic [7:0]  i_sw, i_moles, o_hit_clr;
  logic        o_hit_pulse, o_miss_pulse, o_score_sat;
  logic [15:0] o_score_bcd;

  whack_scorer dut (
    .clk(clk), .rst(rst), .i_tick(i_tick), .i_game_en(i_game_en),
    .i_sw(i_sw), .i_moles(i_moles), .o_hit_clr(o_hit_clr),
    .o_hit_pulse(o_hit_pulse), .o_miss_pulse(o_miss_pulse),
    .o_score_bcd(o_score_bcd), .o_score_sat(o_score_sat)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int hit_cnt = 0, miss_cnt = 0, clr_cnt = 0;
  logic [7:0] last_clr = 8'h00;
  bit fast = 1'b0;
  int sc = 0;
  bit en_prev = 1'b0;

  // Tick every 4 cycles normally, every cycle in fast mode.
  initial begin
    int tcnt;
    tcnt = 0;
    forever begin
      @(negedge clk);
      tcnt++;
      i_tick = fast || (tcnt % 4 == 0);
    end
  end

  always @(posedge clk) begin
    #1;
    if (o_hit_pulse) hit_cnt++;
    if (o_miss_pulse) miss_cnt++;
    if (o_hit_clr != 8'h00) begin
      clr_cnt++;
      last_clr = o_hit_clr;
    end
  end

  function automatic int pop8(input logic [7:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int bcd2int(input logic [15:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: a settled flip on bit i is one whack; hits add, misses optionally subtract.
  task automatic model_event(input logic [7:0] flip, input logic [7:0] moles, input logic en);
    if (en && !en_prev) sc = 0;
    en_prev = en;
    if (en) begin
      sc = sc + pop8(flip & moles);
      if (sc > 9999) sc = 9999;
`ifdef WHACK_MISS_PENALTY_EN
      sc = sc - pop8(flip & ~moles);
      if (sc < 0) sc = 0;
`endif
    end
  endtask

  task automatic run_event(input logic [7:0] flip, input logic [7:0] moles, input logic en,
                           output int dh, output int dm, output int dc);
    int h0, m0, c0;
    @(negedge clk);
    h0 = hit_cnt; m0 = miss_cnt; c0 = clr_cnt;
    i_moles = moles;
    i_game_en = en;
    i_sw = i_sw ^ flip;
    repeat (fast ? 36 : 110) @(negedge clk);
    dh = hit_cnt - h0; dm = miss_cnt - m0; dc = clr_cnt - c0;
  endtask

  task automatic check_event(input string nm, input logic [7:0] flip, input logic [7:0] moles,
                             input logic en);
    logic [7:0] h, m;
    int dh, dm, dc;
    h = en ? (flip & moles) : 8'h00;
    m = en ? (flip & ~moles) : 8'h00;
    run_event(flip, moles, en, dh, dm, dc);
    model_event(flip, moles, en);
    chk({nm, "_clr_cycles"}, dc, int'(h != 8'h00));
    if (h != 8'h00) chk({nm, "_clr"}, int'(last_clr), int'(h));
    chk({nm, "_hit"}, dh, int'(h != 8'h00));
    chk({nm, "_miss"}, dm, int'(m != 8'h00));
    chk({nm, "_score"}, bcd2int(o_score_bcd), sc);
    chk({nm, "_sat"}, int'(o_score_sat), int'(sc == 9999));
  endtask

  task automatic fill(input int n, input logic [7:0] mask);
    int dh, dm, dc;
    for (int k = 0; k < n; k++) begin
      run_event(mask, 8'hFF, 1'b1, dh, dm, dc);
      model_event(mask, 8'hFF, 1'b1);
    end
  endtask

  task automatic glitch(input string nm, input logic [7:0] mask);
    int h0, m0;
    @(negedge clk);
    h0 = hit_cnt; m0 = miss_cnt;
    i_sw = i_sw ^ mask;
    repeat (4) @(negedge clk);
    i_sw = i_sw ^ mask;
    repeat (110) @(negedge clk);
    chk({nm, "_pulses"}, (hit_cnt - h0) + (miss_cnt - m0), 0);
    chk({nm, "_score"}, bcd2int(o_score_bcd), sc);
  endtask

  task automatic new_game();
    @(negedge clk);
    i_game_en = 1'b0;
    repeat (3) @(negedge clk);
    i_game_en = 1'b1;
    repeat (3) @(negedge clk);
    sc = 0;
    en_prev = 1'b1;
    chk("new_game_score", bcd2int(o_score_bcd), 0);
  endtask

  typedef struct {
    logic [7:0] flip;
    logic [7:0] moles;
    logic       en;
    logic [7:0] e_clr;
    int         e_hit;
    int         e_miss;
    int         e_off;
    int         e_on;
  } vec_t;

  vec_t tab[6];

  initial begin
    int h0, m0, c0, dh, dm, dc, exp_sc, seq[8];
    bit got;
    tab[0] = '{8'h10, 8'h10, 1'b1, 8'h10, 1, 0, 3, 3};
    tab[1] = '{8'h01, 8'h00, 1'b1, 8'h00, 0, 1, 3, 2};
    tab[2] = '{8'h03, 8'h01, 1'b1, 8'h01, 1, 1, 4, 2};
    tab[3] = '{8'hC0, 8'hFF, 1'b1, 8'hC0, 1, 0, 6, 4};
    tab[4] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 0, 1, 6, 0};
    tab[5] = '{8'h02, 8'h00, 1'b0, 8'h00, 0, 0, 6, 0};

    // Reset with switches 0F already up.
    rst = 1'b1; i_game_en = 1'b0; i_moles = 8'h00; i_sw = 8'h0F;
    repeat (6) @(negedge clk);
    chk("rst_clr", int'(o_hit_clr), 0);
    chk("rst_hit", int'(o_hit_pulse), 0);
    chk("rst_miss", int'(o_miss_pulse), 0);
    chk("rst_score", int'(o_score_bcd), 0);
    chk("rst_sat", int'(o_score_sat), 0);
    h0 = hit_cnt; m0 = miss_cnt;
    rst = 1'b0; i_game_en = 1'b1; i_moles = 8'hFF;
    repeat (160) @(negedge clk);
    en_prev = 1'b1; sc = 0;
    chk("prime_pulses", (hit_cnt - h0) + (miss_cnt - m0), 0);
    chk("prime_score", bcd2int(o_score_bcd), 0);

    check_event("hit_sw2", 8'h04, 8'h04, 1'b1);

    // Bounce sw[5] every 3 ticks, then settle on the flipped level.
    @(negedge clk);
    h0 = hit_cnt; m0 = miss_cnt; c0 = clr_cnt;
    i_moles = 8'h20;
    for (int k = 0; k < 17; k++) begin
      i_sw[5] = ~i_sw[5];
      repeat (12) @(negedge clk);
    end
    repeat (110) @(negedge clk);
    model_event(8'h20, 8'h20, 1'b1);
    chk("bounce_hit", hit_cnt - h0, 1);
    chk("bounce_miss", miss_cnt - m0, 0);
    chk("bounce_clr_cycles", clr_cnt - c0, 1);
    chk("bounce_score", bcd2int(o_score_bcd), sc);

    i_moles = 8'hFF;
    glitch("glitch_1tick", 8'h10);

    // Directed table.
    for (int v = 0; v < 6; v++) begin
      run_event(tab[v].flip, tab[v].moles, tab[v].en, dh, dm, dc);
`ifdef WHACK_MISS_PENALTY_EN
      exp_sc = tab[v].e_on;
`else
      exp_sc = tab[v].e_off;
`endif
      sc = exp_sc; en_prev = tab[v].en;
      chk($sformatf("tab%0d_hit", v), dh, tab[v].e_hit);
      chk($sformatf("tab%0d_miss", v), dm, tab[v].e_miss);
      chk($sformatf("tab%0d_clr_cycles", v), dc, int'(tab[v].e_clr != 8'h00));
      if (tab[v].e_clr != 8'h00) chk($sformatf("tab%0d_clr", v), int'(last_clr), int'(tab[v].e_clr));
      chk($sformatf("tab%0d_score", v), bcd2int(o_score_bcd), exp_sc);
    end
    new_game();

    // Randomized events and glitches.
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 4) == 0) begin
        i_game_en = 1'b1;
        if (!en_prev) begin en_prev = 1'b1; sc = 0; end
        glitch("rnd_glitch", 8'($urandom_range(1, 255)));
      end else begin
        check_event("rnd", 8'($urandom), 8'($urandom), $urandom_range(0, 5) != 0);
      end
    end

    // Carry chain 0998 -> 1001.
    new_game();
    fast = 1'b1;
    fill(124, 8'hFF);
    fill(1, 8'h3F);
    chk("fill998", bcd2int(o_score_bcd), 998);
    @(negedge clk);
    h0 = hit_cnt; c0 = clr_cnt;
    i_moles = 8'hFF;
    i_sw = i_sw ^ 8'h89;
    got = 1'b0;
    for (int w = 0; w < 60 && !got; w++) begin
      @(negedge clk);
      if (hit_cnt != h0) got = 1'b1;
    end
    chk("carry_pulse_seen", int'(got), 1);
    for (int k = 0; k < 8; k++) begin
      seq[k] = bcd2int(o_score_bcd);
      @(negedge clk);
    end
    got = 1'b0;
    for (int k = 0; k < 5; k++)
      if (seq[k] == 998 && seq[k+1] == 999 && seq[k+2] == 1000 && seq[k+3] == 1001) got = 1'b1;
    chk("carry_steps", int'(got), 1);
    chk("carry_clr", int'(last_clr), 8'h89);
    chk("carry_clr_cycles", clr_cnt - c0, 1);
    repeat (10) @(negedge clk);
    model_event(8'h89, 8'hFF, 1'b1);
    chk("carry_final", bcd2int(o_score_bcd), sc);

    // Saturation at 9999.
    fill(1124, 8'hFF);
    fill(1, 8'h1F);
    chk("fill9998", bcd2int(o_score_bcd), 9998);
    check_event("sat3", 8'h07, 8'hFF, 1'b1);
    check_event("sat_more", 8'h08, 8'hFF, 1'b1);
    check_event("sat_miss", 8'h01, 8'h00, 1'b1);

    // Reset while draining.
    @(negedge clk);
    h0 = hit_cnt;
    i_moles = 8'hFF;
    i_sw = i_sw ^ 8'hFF;
    got = 1'b0;
    for (int w = 0; w < 60 && !got; w++) begin
      @(negedge clk);
      if (hit_cnt != h0) got = 1'b1;
    end
    chk("rstadj_pulse_seen", int'(got), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstadj_score_now", bcd2int(o_score_bcd), 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    sc = 0;
    chk("rstadj_score_hold", bcd2int(o_score_bcd), 0);
    chk("rstadj_sat", int'(o_score_sat), 0);
    chk("rstadj_hits", hit_cnt - h0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
